// File: rtl/sb_pkg.sv
// Shared definitions for the sideband transaction scheduler: tx_kind codes,
// FSM state encoding and the AT timeout/retry defaults.
package sb_pkg;

  localparam int unsigned AT_TIMEOUT_DEF = 1000;
  localparam int unsigned MAX_RETRY_DEF  = 3;

  localparam logic [1:0] KIND_LT     = 2'd0;
  localparam logic [1:0] KIND_AT_CMD = 2'd1;
  localparam logic [1:0] KIND_AT_RSP = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/sb_at_timer.sv
// AT command response tracking: outstanding flag, response timer, retry counter
// and done/fail pulses. Retransmission is enabled by SB_SCHED_RETRY_EN.
module sb_at_timer
  import sb_pkg::*;
#(
  parameter int unsigned AT_TIMEOUT = AT_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cmd_sent_i,
  input  logic rsp_rcvd_i,
  output logic at_pending_o,
  output logic retx_pend_o,
  output logic at_done_o,
  output logic at_fail_o
);

  localparam int unsigned TimerW = ($clog2(AT_TIMEOUT) > 0) ? $clog2(AT_TIMEOUT) : 1;
  localparam int unsigned RetryW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef SB_SCHED_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              pending_q, pending_d;
  logic              retx_q, retx_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              timeout;

  // The timer is frozen while a retransmit waits for or occupies the link.
  assign timeout = pending_q && !retx_q && (timer_q == TimerW'(AT_TIMEOUT - 1));

  always_comb begin
    timer_d   = timer_q;
    retry_d   = retry_q;
    pending_d = pending_q;
    retx_d    = retx_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    if (pending_q && !retx_q) timer_d = timer_q + TimerW'(1);
    if (retx_q) timer_d = '0;
    if (rsp_rcvd_i && pending_q) begin
      pending_d = 1'b0;
      retry_d   = '0;
      retx_d    = 1'b0;
      timer_d   = '0;
      done_d    = 1'b1;
    end else if (timeout) begin
      timer_d = '0;
      if (RetryEn && (retry_q < RetryW'(MAX_RETRY))) begin
        retx_d  = 1'b1;
        retry_d = retry_q + RetryW'(1);
      end else begin
        fail_d    = 1'b1;
        pending_d = 1'b0;
        retry_d   = '0;
      end
    end
    if (cmd_sent_i) begin
      pending_d = 1'b1;
      timer_d   = '0;
      retx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      retry_q   <= '0;
      pending_q <= 1'b0;
      retx_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pending_q <= pending_d;
      retx_q    <= retx_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign at_pending_o = pending_q;
  assign retx_pend_o  = retx_q;
  assign at_done_o    = done_q;
  assign at_fail_o    = fail_q;

endmodule

// File: rtl/sb_txn_scheduler.sv
// Sideband transaction scheduler: fixed-priority arbiter feeding a serializer,
// with AT command tracking. Define SB_SCHED_RETRY_EN to enable AT retransmission.
module sb_txn_scheduler
  import sb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AT_TIMEOUT = AT_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              lt_req,
  input  logic [DATA_W-1:0] lt_data,
  output logic              lt_ack,
  input  logic              at_rsp_req,
  input  logic [DATA_W-1:0] at_rsp_data,
  output logic              at_rsp_ack,
  input  logic              at_cmd_req,
  input  logic [DATA_W-1:0] at_cmd_data,
  output logic              at_cmd_ack,
  output logic              tx_valid,
  output logic [1:0]        tx_kind,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rsp_rcvd,
  output logic              at_done,
  output logic              at_fail,
  output logic              at_pending
);

  logic [1:0]        state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [1:0]        tx_kind_q, tx_kind_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              lt_ack_q, lt_ack_d;
  logic              rsp_ack_q, rsp_ack_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic [DATA_W-1:0] retx_data;
  logic              retx_pend;
  logic              cmd_sent;

  // Covers both first transmissions and retransmits of the AT command.
  assign cmd_sent = (state_q == ST_SEND) && tx_ready && (tx_kind_q == KIND_AT_CMD);

`ifdef SB_SCHED_RETRY_EN
  logic [DATA_W-1:0] retx_data_q;
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) retx_data_q <= '0;
    else if (cmd_sent) retx_data_q <= tx_data_q;
  end
  assign retx_data = retx_data_q;
`else
  assign retx_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_kind_d  = tx_kind_q;
    tx_data_d  = tx_data_q;
    lt_ack_d   = 1'b0;
    rsp_ack_d  = 1'b0;
    cmd_ack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lt_req) begin
          {state_d, tx_valid_d, tx_kind_d, tx_data_d} = {ST_SEND, 1'b1, KIND_LT, lt_data};
          lt_ack_d = 1'b1;
        end else if (at_rsp_req) begin
          {state_d, tx_valid_d, tx_kind_d, tx_data_d} = {ST_SEND, 1'b1, KIND_AT_RSP, at_rsp_data};
          rsp_ack_d = 1'b1;
        end else if (retx_pend) begin
          {state_d, tx_valid_d, tx_kind_d, tx_data_d} = {ST_SEND, 1'b1, KIND_AT_CMD, retx_data};
        end else if (at_cmd_req && !at_pending) begin
          {state_d, tx_valid_d, tx_kind_d, tx_data_d} = {ST_SEND, 1'b1, KIND_AT_CMD, at_cmd_data};
          cmd_ack_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_kind_q  <= 2'd0;
      tx_data_q  <= '0;
      lt_ack_q   <= 1'b0;
      rsp_ack_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_kind_q  <= tx_kind_d;
      tx_data_q  <= tx_data_d;
      lt_ack_q   <= lt_ack_d;
      rsp_ack_q  <= rsp_ack_d;
      cmd_ack_q  <= cmd_ack_d;
    end
  end

  sb_at_timer #(
    .AT_TIMEOUT(AT_TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_at_timer (
    .clk_i       (sb_clk),
    .rst_ni      (rst),
    .cmd_sent_i  (cmd_sent),
    .rsp_rcvd_i  (rsp_rcvd),
    .at_pending_o(at_pending),
    .retx_pend_o (retx_pend),
    .at_done_o   (at_done),
    .at_fail_o   (at_fail)
  );

  assign tx_valid   = tx_valid_q;
  assign tx_kind    = tx_kind_q;
  assign tx_data    = tx_data_q;
  assign lt_ack     = lt_ack_q;
  assign at_rsp_ack = rsp_ack_q;
  assign at_cmd_ack = cmd_ack_q;

endmodule

// File: tb/tb_sb_txn_scheduler.sv
// Self-checking bench for sb_txn_scheduler (AT_TIMEOUT=20, MAX_RETRY=3); follows
// SB_SCHED_RETRY_EN to pick the expected timeout behaviour.
module tb_sb_txn_scheduler;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        lt_req, at_rsp_req, at_cmd_req;
  logic [31:0] lt_data, at_rsp_data, at_cmd_data;
  logic        lt_ack, at_rsp_ack, at_cmd_ack;
  logic        tx_valid, tx_ready;
  logic [1:0]  tx_kind;
  logic [31:0] tx_data;
  logic        rsp_rcvd, at_done, at_fail, at_pending;

  sb_txn_scheduler #(
    .DATA_W    (32),
    .AT_TIMEOUT(20),
    .MAX_RETRY (3)
  ) dut (
    .sb_clk     (sb_clk),
    .rst        (rst),
    .lt_req     (lt_req),
    .lt_data    (lt_data),
    .lt_ack     (lt_ack),
    .at_rsp_req (at_rsp_req),
    .at_rsp_data(at_rsp_data),
    .at_rsp_ack (at_rsp_ack),
    .at_cmd_req (at_cmd_req),
    .at_cmd_data(at_cmd_data),
    .at_cmd_ack (at_cmd_ack),
    .tx_valid   (tx_valid),
    .tx_kind    (tx_kind),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rsp_rcvd   (rsp_rcvd),
    .at_done    (at_done),
    .at_fail    (at_fail),
    .at_pending (at_pending)
  );

  always #5 sb_clk = ~sb_clk;

  // Transfer log and pulse counters, sampled mid-cycle.
  logic [1:0]  mk[$];
  logic [31:0] md[$];
  int          mt[$];
  int cyc = 0, n_lt = 0, n_rsp = 0, n_cmd = 0, n_done = 0, n_fail = 0;
  always @(negedge sb_clk) begin
    cyc++;
    if (tx_valid && tx_ready) begin
      mk.push_back(tx_kind);
      md.push_back(tx_data);
      mt.push_back(cyc);
    end
    if (lt_ack) n_lt++;
    if (at_rsp_ack) n_rsp++;
    if (at_cmd_ack) n_cmd++;
    if (at_done) n_done++;
    if (at_fail) n_fail++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, a_lt, a_rsp, a_cmd, a_done, a_fail;
    logic [31:0] dl, dr, dc, d;
    logic        do_lt, do_rsp;
    logic [1:0]  ek[$];
    logic [31:0] ed[$];

    rst = 1'b0; lt_req = 0; at_rsp_req = 0; at_cmd_req = 0; rsp_rcvd = 0; tx_ready = 1;
    lt_data = '0; at_rsp_data = '0; at_cmd_data = '0;
    #3;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_kind", tx_kind, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_acks", {lt_ack, at_rsp_ack, at_cmd_ack}, 0);
    chk("rst_status", {at_done, at_fail, at_pending}, 0);
    step(); step(); rst = 1'b1; step();

    // Three simultaneous requesters: order LT, AT_RSP, AT_CMD with one-cycle gaps.
    base = mk.size(); a_lt = n_lt; a_rsp = n_rsp; a_cmd = n_cmd;
    dl = $urandom; dr = $urandom; dc = $urandom;
    lt_req = 1; lt_data = dl; at_rsp_req = 1; at_rsp_data = dr; at_cmd_req = 1; at_cmd_data = dc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (lt_ack) lt_req = 0;
      if (at_rsp_ack) at_rsp_req = 0;
      if (at_cmd_ack) at_cmd_req = 0;
      if (!lt_req && !at_rsp_req && !at_cmd_req && mk.size() >= base + 3) break;
    end
    chk("prio_count", mk.size() - base, 3);
    if (mk.size() >= base + 3) begin
      chk("prio_kind0", mk[base], 0);
      chk("prio_kind1", mk[base+1], 2);
      chk("prio_kind2", mk[base+2], 1);
      chk("prio_data0", md[base], dl);
      chk("prio_data1", md[base+1], dr);
      chk("prio_data2", md[base+2], dc);
      chk("prio_gap01", mt[base+1] - mt[base], 3);
      chk("prio_gap12", mt[base+2] - mt[base+1], 3);
    end
    chk("prio_acks", {n_lt - a_lt, n_rsp - a_rsp, n_cmd - a_cmd}, {32'd1, 32'd1, 32'd1});
    chk("prio_pending", at_pending, 1);
    rsp_rcvd = 1; step(); rsp_rcvd = 0;
    chk("prio_done", at_done, 1);
    chk("prio_pending_clr", at_pending, 0);
    step();
    chk("prio_done_1cyc", at_done, 0);

    // Back-pressure hold, then response 10 cycles after the transfer.
    base = mk.size(); a_cmd = n_cmd; a_fail = n_fail;
    tx_ready = 0; at_cmd_data = 32'hA5A5_0001; at_cmd_req = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, 32'hA5A5_0001);
      chk("hold_kind", tx_kind, 1);
      chk("hold_ack", at_cmd_ack, (i == 0) ? 1 : 0);
      if (at_cmd_ack) at_cmd_req = 0;
      step();
    end
    tx_ready = 1;
    chk("hold_valid_last", tx_valid, 1);
    step();
    chk("hold_gap", tx_valid, 0);
    repeat (9) step();
    rsp_rcvd = 1; step(); rsp_rcvd = 0;
    chk("rsp_done", at_done, 1);
    chk("rsp_pending", at_pending, 0);
    repeat (40) step();
    chk("rsp_no_retx", mk.size() - base, 1);
    if (mk.size() > base) chk("rsp_data", md[base], 32'hA5A5_0001);
    chk("rsp_cmd_acks", n_cmd - a_cmd, 1);
    chk("rsp_no_fail", n_fail - a_fail, 0);

    // Response arrives in the exact timeout cycle.
    base = mk.size(); a_fail = n_fail;
    d = $urandom; at_cmd_data = d; at_cmd_req = 1;
    step();
    at_cmd_req = 0;
    chk("edge_xfer", tx_valid, 1);
    repeat (20) step();
    chk("edge_pending", at_pending, 1);
    chk("edge_no_early", {at_done, at_fail}, 0);
    rsp_rcvd = 1; step(); rsp_rcvd = 0;
    chk("edge_done", at_done, 1);
    chk("edge_no_fail", at_fail, 0);
    chk("edge_pending_clr", at_pending, 0);
    repeat (40) step();
    chk("edge_no_retx", mk.size() - base, 1);
    chk("edge_fail_cnt", n_fail - a_fail, 0);

    // No response at all.
    base = mk.size(); a_fail = n_fail; a_cmd = n_cmd;
    d = $urandom; at_cmd_data = d; at_cmd_req = 1;
    step();
    at_cmd_req = 0;
    repeat (20) step();
    chk("to_not_yet", at_fail, 0);
    chk("to_pending", at_pending, 1);
    step();
`ifdef SB_SCHED_RETRY_EN
    chk("retry_first_no_fail", at_fail, 0);
    chk("retry_still_pending", at_pending, 1);
    for (int i = 0; i < 300; i++) begin
      if (at_fail) break;
      step();
    end
    chk("retry_fail", at_fail, 1);
    chk("retry_pending_clr", at_pending, 0);
    step();
    chk("retry_xfers", mk.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (mk.size() > base + i) begin
        chk("retry_kind", mk[base+i], 1);
        chk("retry_data", md[base+i], d);
      end
    end
`else
    chk("to_fail", at_fail, 1);
    chk("to_pending_clr", at_pending, 0);
    step();
    chk("to_fail_1cyc", at_fail, 0);
    repeat (40) step();
    chk("to_no_retx", mk.size() - base, 1);
`endif
    chk("to_fail_cnt", n_fail - a_fail, 1);
    chk("to_cmd_acks", n_cmd - a_cmd, 1);

    // Random LT/AT_RSP traffic under random back-pressure against a priority scoreboard.
    base = mk.size(); a_cmd = n_cmd;
    for (int r = 0; r < 20; r++) begin
      do_lt = ($urandom_range(0, 1) == 1);
      do_rsp = ($urandom_range(0, 1) == 1);
      if (!do_lt && !do_rsp) do_lt = 1;
      dl = $urandom; dr = $urandom;
      lt_req = do_lt; lt_data = dl; at_rsp_req = do_rsp; at_rsp_data = dr;
      if (do_lt) begin ek.push_back(2'd0); ed.push_back(dl); end
      if (do_rsp) begin ek.push_back(2'd2); ed.push_back(dr); end
      for (int i = 0; i < 100; i++) begin
        tx_ready = ($urandom_range(0, 1) == 1);
        step();
        if (lt_ack) lt_req = 0;
        if (at_rsp_ack) at_rsp_req = 0;
        if (!lt_req && !at_rsp_req) break;
      end
      chk("rnd_acked", {lt_req, at_rsp_req}, 0);
      lt_req = 0; at_rsp_req = 0;
      tx_ready = 1;
      repeat (3) step();
    end
    chk("rnd_count", mk.size() - base, ek.size());
    for (int i = 0; i < ek.size(); i++) begin
      if (mk.size() > base + i) begin
        chk("rnd_kind", mk[base+i], ek[i]);
        chk("rnd_data", md[base+i], ed[i]);
      end
    end
    chk("rnd_no_cmd_ack", n_cmd - a_cmd, 0);

    // Reset in the middle of a SEND.
    lt_req = 1; lt_data = $urandom; tx_ready = 0;
    step();
    chk("mrst_pre_valid", tx_valid, 1);
    lt_req = 0;
    #2 rst = 0;
    #1;
    chk("mrst_valid", tx_valid, 0);
    chk("mrst_data", tx_data, 0);
    chk("mrst_acks", {lt_ack, at_rsp_ack, at_cmd_ack}, 0);
    step(); rst = 1; tx_ready = 1; step();

    // Reset while an AT command is outstanding.
    d = $urandom; at_cmd_data = d; at_cmd_req = 1;
    step();
    at_cmd_req = 0;
    repeat (5) step();
    chk("wrst_pre_pending", at_pending, 1);
    base = mk.size(); a_done = n_done; a_fail = n_fail; a_cmd = n_cmd;
    #2 rst = 0;
    #1;
    chk("wrst_status", {at_pending, at_done, at_fail}, 0);
    chk("wrst_valid", tx_valid, 0);
    step(); rst = 1;
    repeat (40) step();
    chk("wrst_no_xfer", mk.size() - base, 0);
    chk("wrst_no_done", n_done - a_done, 0);
    chk("wrst_no_fail", n_fail - a_fail, 0);
    chk("wrst_no_ack", n_cmd - a_cmd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
